// File: rtl/afe_spi_multichain.sv
// N independent write-only SPI chains (SCLK/SDI/LE) fed from one CSR write port.
// Optional SDO readback capture when AFE_SPI_READBACK_EN is defined.
module afe_spi_multichain #(
  parameter int CHANNEL_COUNT = 2,
  parameter int DATA_WIDTH    = 24,
  parameter int SYSCLK_RATE   = 99999001,
  parameter int SPI_CLK_RATE  = 10000000,
  localparam int CW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                                sysClk,
  input  logic                                sysReset,
  input  logic                                writeStrobe,
  input  logic [CW-1:0]                       writeChannel,
  input  logic [DATA_WIDTH-1:0]               writeData,
  output logic [CHANNEL_COUNT-1:0]            busy,
  output logic [CHANNEL_COUNT-1:0]            overrun,
  output logic [CHANNEL_COUNT*DATA_WIDTH-1:0] readData,
  output logic [CHANNEL_COUNT-1:0]            spiClk,
  output logic [CHANNEL_COUNT-1:0]            spiSdi,
  output logic [CHANNEL_COUNT-1:0]            spiLe,
  input  logic [CHANNEL_COUNT-1:0]            spiSdo
);

  localparam longint H_L =
    (longint'(SYSCLK_RATE) + 2 * longint'(SPI_CLK_RATE) - 1) /
    (2 * longint'(SPI_CLK_RATE));
  localparam int H    = (H_L < 1) ? 1 : int'(H_L);
  localparam int CNTW = $clog2(2 * H);
  localparam int BW   = $clog2(DATA_WIDTH);

  localparam logic [CNTW-1:0] H_M1     = CNTW'(H - 1);
  localparam logic [CNTW-1:0] LE_M1    = CNTW'(2 * H - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_GAP
  } state_t;

  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_ch
    state_t                r_st, w_st_n;
    logic [CNTW-1:0]       r_cnt, w_cnt_n;
    logic                  r_ph, w_ph_n;
    logic [BW-1:0]         r_bit, w_bit_n;
    logic [DATA_WIDTH-1:0] r_sh, w_sh_n;
    logic                  r_ovr, w_ovr_n;
    logic                  w_sel;
`ifdef AFE_SPI_READBACK_EN
    logic [DATA_WIDTH-1:0] r_cap, w_cap_n;
    logic [DATA_WIDTH-1:0] r_rd, w_rd_n;
`endif

    // Out-of-range indices match no chain and are dropped silently
    assign w_sel = writeStrobe && (writeChannel == CW'(g));

    always_ff @(posedge sysClk or posedge sysReset) begin
      if (sysReset) begin
        r_st  <= S_IDLE;
        r_cnt <= '0;
        r_ph  <= 1'b0;
        r_bit <= '0;
        r_sh  <= '0;
        r_ovr <= 1'b0;
`ifdef AFE_SPI_READBACK_EN
        r_cap <= '0;
        r_rd  <= '0;
`endif
      end else begin
        r_st  <= w_st_n;
        r_cnt <= w_cnt_n;
        r_ph  <= w_ph_n;
        r_bit <= w_bit_n;
        r_sh  <= w_sh_n;
        r_ovr <= w_ovr_n;
`ifdef AFE_SPI_READBACK_EN
        r_cap <= w_cap_n;
        r_rd  <= w_rd_n;
`endif
      end
    end

    always_comb begin
      w_st_n  = r_st;
      w_cnt_n = r_cnt + 1'b1;
      w_ph_n  = r_ph;
      w_bit_n = r_bit;
      w_sh_n  = r_sh;
      w_ovr_n = r_ovr;
`ifdef AFE_SPI_READBACK_EN
      w_cap_n = r_cap;
      w_rd_n  = r_rd;
      // Sample SDO during the first sysClk cycle of each SCLK high phase
      if (r_st == S_SHIFT && r_ph && r_cnt == '0)
        w_cap_n = {r_cap[DATA_WIDTH-2:0], spiSdo[g]};
`endif
      unique case (r_st)
        S_IDLE: begin
          w_cnt_n = '0;
          if (w_sel) begin
            w_st_n  = S_SHIFT;
            w_ph_n  = 1'b0;
            w_bit_n = '0;
            w_sh_n  = writeData;
            w_ovr_n = 1'b0;
          end
        end
        S_SHIFT: begin
          if (r_cnt == H_M1) begin
            w_cnt_n = '0;
            if (!r_ph) begin
              w_ph_n = 1'b1;
            end else begin
              w_ph_n = 1'b0;
              if (r_bit == BIT_LAST) begin
                w_st_n = S_LATCH;
`ifdef AFE_SPI_READBACK_EN
                w_rd_n = w_cap_n;
`endif
              end else begin
                w_bit_n = r_bit + 1'b1;
                w_sh_n  = r_sh << 1;
              end
            end
          end
        end
        S_LATCH: begin
          if (r_cnt == LE_M1) begin
            w_st_n  = S_GAP;
            w_cnt_n = '0;
          end
        end
        S_GAP: begin
          if (r_cnt == H_M1) begin
            w_st_n  = S_IDLE;
            w_cnt_n = '0;
          end
        end
        default: w_st_n = S_IDLE;
      endcase
      if (w_sel && r_st != S_IDLE)
        w_ovr_n = 1'b1;
    end

    assign busy[g]    = (r_st != S_IDLE);
    assign overrun[g] = r_ovr;
    assign spiClk[g]  = (r_st == S_SHIFT) && r_ph;
    assign spiSdi[g]  = (r_st == S_SHIFT) && r_sh[DATA_WIDTH-1];
    assign spiLe[g]   = (r_st == S_LATCH);
`ifdef AFE_SPI_READBACK_EN
    assign readData[g*DATA_WIDTH +: DATA_WIDTH] = r_rd;
`endif
  end

`ifndef AFE_SPI_READBACK_EN
  logic w_unused_sdo;
  assign w_unused_sdo = ^spiSdo;
  assign readData = '0;
`endif

endmodule
